// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcode and load-width encodings plus common datapath types.
package riscv_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Extend a narrow load value to a full word, signed or unsigned.
  function automatic word_t extend16(input logic [15:0] val, input logic sign_en);
    extend16 = {{16{sign_en & val[15]}}, val};
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: lane select, sign/zero extension and alignment check.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  input  word_t      data_read_i,
  output word_t      word_o,
  output logic       misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = data_read_i[8*addr_lo_i +: 8];
  assign half_s = data_read_i[16*addr_lo_i[1] +: 16];

  // Width/sign decode; unsupported widths return zero and flag as misaligned.
  always_comb begin
    word_o       = '0;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB: begin
        word_o       = extend16({{8{byte_s[7]}}, byte_s}, 1'b1);
        misaligned_o = 1'b0;
      end
      F3_LBU: begin
        word_o       = {24'd0, byte_s};
        misaligned_o = 1'b0;
      end
      F3_LH: begin
        word_o       = extend16(half_s, 1'b1);
        misaligned_o = addr_lo_i[0];
      end
      F3_LHU: begin
        word_o       = extend16(half_s, 1'b0);
        misaligned_o = addr_lo_i[0];
      end
      F3_LW: begin
        word_o       = data_read_i;
        misaligned_o = (addr_lo_i != 2'd0);
      end
      default: begin
        word_o       = '0;
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file with write-through read ports,
// a sticky misaligned-load flag and a retired-writeback counter.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      MEMWB_opcode_out,
  input  logic [2:0]      MEMWB_funct3_out,
  input  logic [XLEN-1:0] MEMWB_data_addr_out,
  input  logic            MEMWB_register_write_valid_out,
  input  reg_addr_t       MEMWB_write_reg_out,
  input  logic [XLEN-1:0] MEMWB_reg_write_data_out,
  input  logic [XLEN-1:0] MEMWB_data_read,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_en,
  output reg_addr_t       wb_reg,
  output logic [XLEN-1:0] wb_data,
  output logic            load_misaligned,
  output logic [XLEN-1:0] wb_count
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] wb_count_q, wb_count_d;
  logic            load_misaligned_q, load_misaligned_d;

  word_t     fmt_word_s;
  logic      fmt_mis_s;
  logic      is_load_s;
  logic      misaligned_s;
  logic      wb_en_s;
  word_t     wb_data_s;
  logic      unused_addr_s;

  assign unused_addr_s = ^MEMWB_data_addr_out[XLEN-1:2];

  load_formatter u_load_formatter (
    .funct3_i     (MEMWB_funct3_out),
    .addr_lo_i    (MEMWB_data_addr_out[1:0]),
    .data_read_i  (MEMWB_data_read),
    .word_o       (fmt_word_s),
    .misaligned_o (fmt_mis_s)
  );

  assign is_load_s    = (MEMWB_opcode_out == OPC_LOAD);
  assign misaligned_s = is_load_s & fmt_mis_s;
  assign wb_data_s    = is_load_s ? fmt_word_s : MEMWB_reg_write_data_out;
  assign wb_en_s      = MEMWB_register_write_valid_out & (MEMWB_write_reg_out != 5'd0) & ~misaligned_s;

  // Next-state for the debug counter and the sticky flag.
  always_comb begin
    wb_count_d        = wb_count_q;
    load_misaligned_d = load_misaligned_q | misaligned_s;
    if (wb_en_s) begin
      wb_count_d = wb_count_q + 32'd1;
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // State update; a write coinciding with reset is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q        <= '0;
      load_misaligned_q <= 1'b0;
    end else begin
      if (wb_en_s) begin
        regs_q[MEMWB_write_reg_out] <= wb_data_s;
      end
      wb_count_q        <= wb_count_d;
      load_misaligned_q <= load_misaligned_d;
    end
  end

  // Read ports: x0 reads zero, an in-flight write to the same rd is bypassed.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_en_s && (MEMWB_write_reg_out == rs1_addr)) begin
      rs1_data = wb_data_s;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_en_s && (MEMWB_write_reg_out == rs2_addr)) begin
      rs2_data = wb_data_s;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  assign wb_en           = wb_en_s;
  assign wb_reg          = MEMWB_write_reg_out;
  assign wb_data         = wb_data_s;
  assign load_misaligned = load_misaligned_q;
  assign wb_count        = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] data_addr;
  logic        valid;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] data_read;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        load_misaligned;
  logic [31:0] wb_count;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk                            (clk),
    .reset                          (reset),
    .MEMWB_opcode_out               (opcode),
    .MEMWB_funct3_out               (funct3),
    .MEMWB_data_addr_out            (data_addr),
    .MEMWB_register_write_valid_out (valid),
    .MEMWB_write_reg_out            (wr_reg),
    .MEMWB_reg_write_data_out       (wr_data),
    .MEMWB_data_read                (data_read),
    .rs1_addr                       (rs1_addr),
    .rs2_addr                       (rs2_addr),
    .rs1_data                       (rs1_data),
    .rs2_data                       (rs2_data),
    .wb_en                          (wb_en),
    .wb_reg                         (wb_reg),
    .wb_data                        (wb_data),
    .load_misaligned                (load_misaligned),
    .wb_count                       (wb_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic v, input logic [4:0] rd, input logic [31:0] d);
    opcode = op; funct3 = f3; data_addr = addr; valid = v; wr_reg = rd; wr_data = d;
  endtask

  logic [2:0]  ld_f3   [7];
  logic [31:0] ld_addr [7];
  logic [31:0] ld_exp  [7];

  initial begin
    reset = 1'b1;
    drive(OP_ALU, 3'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    data_read = 32'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: every register reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rs1_addr = i[4:0];
      rs2_addr = 5'd31 - i[4:0];
      #1;
      chk("reset_rs1", rs1_data, 32'd0);
      chk("reset_rs2", rs2_data, 32'd0);
    end
    chk("reset_count", wb_count, 32'd0);
    chk("reset_flag", {31'd0, load_misaligned}, 32'd0);

    // 2: bypass then array read of x5
    @(negedge clk);
    drive(OP_ALU, 3'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    chk("bypass_rs1", rs1_data, 32'hDEADBEEF);
    chk("bypass_rs2", rs2_data, 32'hDEADBEEF);
    chk("bypass_wben", {31'd0, wb_en}, 32'd1);
    chk("bypass_wbreg", {27'd0, wb_reg}, 32'd5);
    @(posedge clk); #1;
    valid = 1'b0;
    #1;
    chk("array_rs1", rs1_data, 32'hDEADBEEF);
    chk("array_rs2", rs2_data, 32'hDEADBEEF);
    chk("count_1", wb_count, 32'd1);

    // 3: load formatting, one rd per case starting at x10
    data_read = 32'h80F17F22;
    ld_f3[0] = 3'b000; ld_addr[0] = 32'h00001003; ld_exp[0] = 32'hFFFFFF80;
    ld_f3[1] = 3'b100; ld_addr[1] = 32'h00001003; ld_exp[1] = 32'h00000080;
    ld_f3[2] = 3'b001; ld_addr[2] = 32'h00001000; ld_exp[2] = 32'h00007F22;
    ld_f3[3] = 3'b101; ld_addr[3] = 32'h00001002; ld_exp[3] = 32'h000080F1;
    ld_f3[4] = 3'b010; ld_addr[4] = 32'h00001000; ld_exp[4] = 32'h80F17F22;
    ld_f3[5] = 3'b001; ld_addr[5] = 32'h00001002; ld_exp[5] = 32'hFFFF80F1;
    ld_f3[6] = 3'b000; ld_addr[6] = 32'h00001001; ld_exp[6] = 32'h0000007F;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive(OP_LOAD, ld_f3[k], ld_addr[k], 1'b1, 5'd10 + k[4:0], 32'h55555555);
      rs1_addr = 5'd10 + k[4:0];
      #1;
      chk("load_wbdata", wb_data, ld_exp[k]);
      @(posedge clk); #1;
      valid = 1'b0;
      #1;
      chk("load_array", rs1_data, ld_exp[k]);
    end
    chk("count_8", wb_count, 32'd8);
    chk("no_flag_aligned", {31'd0, load_misaligned}, 32'd0);

    // 4: write to x0 dropped
    @(negedge clk);
    drive(OP_ALU, 3'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
    rs1_addr = 5'd0;
    #1;
    chk("x0_wben", {31'd0, wb_en}, 32'd0);
    chk("x0_rs1", rs1_data, 32'd0);
    @(posedge clk); #1;
    chk("x0_rs1_after", rs1_data, 32'd0);
    chk("x0_count", wb_count, 32'd8);

    // 5: misaligned LW must not disturb x7 and sets the sticky flag
    @(negedge clk);
    drive(OP_ALU, 3'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE0007);
    @(posedge clk);
    @(negedge clk);
    drive(OP_LOAD, 3'b010, 32'h00000102, 1'b1, 5'd7, 32'd0);
    rs1_addr = 5'd7;
    #1;
    chk("mis_wben", {31'd0, wb_en}, 32'd0);
    chk("mis_bypass_old", rs1_data, 32'hCAFE0007);
    chk("mis_flag_pre", {31'd0, load_misaligned}, 32'd0);
    @(posedge clk); #1;
    chk("mis_x7_kept", rs1_data, 32'hCAFE0007);
    chk("mis_flag_set", {31'd0, load_misaligned}, 32'd1);
    chk("mis_count", wb_count, 32'd9);
    @(negedge clk);
    drive(OP_ALU, 3'd0, 32'd0, 1'b1, 5'd8, 32'h00000088);
    rs1_addr = 5'd8;
    @(posedge clk); #1;
    chk("sticky_flag", {31'd0, load_misaligned}, 32'd1);
    chk("after_mis_x8", rs1_data, 32'h00000088);
    chk("count_10", wb_count, 32'd10);

    // 6: back-to-back writes to x9, then reset between edges
    @(negedge clk);
    drive(OP_ALU, 3'd0, 32'd0, 1'b1, 5'd9, 32'h00000001);
    rs1_addr = 5'd9; rs2_addr = 5'd5;
    @(posedge clk);
    @(negedge clk);
    wr_data = 32'h00000002;
    @(posedge clk); #1;
    valid = 1'b0;
    #1;
    chk("x9_second", rs1_data, 32'h00000002);
    chk("count_12", wb_count, 32'd12);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_x9", rs1_data, 32'd0);
    chk("rst_x5", rs2_data, 32'd0);
    chk("rst_count", wb_count, 32'd0);
    chk("rst_flag", {31'd0, load_misaligned}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Unsupported load width is treated as misaligned
    @(negedge clk);
    drive(OP_LOAD, 3'b011, 32'h00000000, 1'b1, 5'd3, 32'd0);
    rs1_addr = 5'd3;
    #1;
    chk("badf3_wben", {31'd0, wb_en}, 32'd0);
    chk("badf3_wbdata", wb_data, 32'd0);
    @(posedge clk); #1;
    chk("badf3_flag", {31'd0, load_misaligned}, 32'd1);
    chk("badf3_x3", rs1_data, 32'd0);
    chk("badf3_count", wb_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
